// File: rtl/uart_tx_shifter_pkg.sv
// uart_tx_shifter_pkg: shared UART transmitter constants, state encoding and parity helper
package uart_tx_shifter_pkg;
  localparam int UART_FIFO_WIDTH = 8;
  localparam int UART_FIFO_COUNTER_W = 5;
  localparam int LCR_STOP = 2;
  localparam int LCR_PE = 3;
  localparam int LCR_EPS = 4;
  localparam int LCR_SP = 5;
  localparam int LCR_BC = 6;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP1  = 3'd5,
    S_STOP2  = 3'd6
  } tx_state_e;
  // mode = {stick, even}; x = XOR of the data bits sent
  function automatic logic parity_bit(input logic [1:0] mode, input logic x);
    return mode[1] ? ~mode[0] : (mode[0] ? x : ~x);
  endfunction
endpackage

// File: rtl/uart_tx_shifter_if.sv
// uart_tx_shifter_if: TX FIFO read port (head word, occupancy, pop strobe)
// master: FIFO side drives tf_data_out/tf_count; slave: shifter side drives tf_pop
interface uart_tx_shifter_if
  import uart_tx_shifter_pkg::*;
#(
  parameter int fifo_width = UART_FIFO_WIDTH,
  parameter int fifo_counter_w = UART_FIFO_COUNTER_W
);
  logic [fifo_width-1:0] tf_data_out;
  logic [fifo_counter_w-1:0] tf_count;
  logic tf_pop;
  modport master (output tf_data_out, output tf_count, input tf_pop);
  modport slave (input tf_data_out, input tf_count, output tf_pop);
endinterface

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: UART serialiser pulling words from the TX FIFO, 16 enables per bit
// Ports: clk, wb_rst_i (async, active high), enable (16x baud pulse), lcr (line control),
//        tf (TX FIFO slave port), stx_pad_o (registered serial line), tstate, tx_busy
module uart_tx_shifter
  import uart_tx_shifter_pkg::*;
#(
  parameter int fifo_width = UART_FIFO_WIDTH,
  parameter int fifo_counter_w = UART_FIFO_COUNTER_W
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  enable,
  input  logic [7:0]            lcr,
  uart_tx_shifter_if.slave      tf,
  output logic                  stx_pad_o,
  output logic [2:0]            tstate,
  output logic                  tx_busy
);
  tx_state_e state_q, state_d, frame_end;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [fifo_width-1:0] shift_q, shift_d;
  logic par_q, par_d;
  logic stx_q, stx_d;
  logic line_d;
  logic [fifo_counter_w-1:0] count;
  logic nonempty, last_data, lcr_unused;
  assign count = tf.tf_count;
  assign nonempty = count != '0;
  assign last_data = bit_q == 3'(lcr[1:0]) + 3'd4;
  assign frame_end = nonempty ? S_POP : S_IDLE;
  assign lcr_unused = lcr[7];
  assign stx_pad_o = stx_q;
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      tick_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      stx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      stx_q <= stx_d;
    end
  end
  // par_q accumulates the data XOR, then holds the final parity bit so a
  // mid-bit lcr change cannot disturb the PARITY bit
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    if (state_q == S_POP) begin
      state_d = S_START;
      tick_d = 4'd15;
      bit_d = '0;
      shift_d = tf.tf_data_out;
      par_d = 1'b0;
    end else if (state_q == S_IDLE) begin
      if (enable && nonempty) state_d = S_POP;
    end else if (enable) begin
      tick_d = tick_q - 4'd1;
      if (tick_q == 4'd0) begin
        tick_d = 4'd15;
        case (state_q)
          S_START: state_d = S_DATA;
          S_DATA: begin
            shift_d = shift_q >> 1;
            bit_d = bit_q + 3'd1;
            par_d = par_q ^ shift_q[0];
            if (last_data) begin
              state_d = lcr[LCR_PE] ? S_PARITY : S_STOP1;
              par_d = parity_bit(lcr[LCR_SP:LCR_EPS], par_q ^ shift_q[0]);
            end
          end
          S_PARITY: state_d = S_STOP1;
          S_STOP1: begin
            state_d = lcr[LCR_STOP] ? S_STOP2 : frame_end;
            // 5-bit words with two stop bits use a half-length second stop bit
            if (lcr[LCR_STOP] && lcr[1:0] == 2'b00) tick_d = 4'd7;
          end
          default: state_d = frame_end;
        endcase
      end
    end
  end
  // line level follows the registered-next state so stx_pad_o changes only at bit boundaries
  always_comb begin
    tf.tf_pop = state_q == S_POP && nonempty;
    tx_busy = state_q != S_IDLE;
    tstate = state_q;
    line_d = state_d == S_START ? 1'b0 :
             state_d == S_DATA ? shift_d[0] :
             state_d == S_PARITY ? par_d : 1'b1;
    stx_d = line_d & ~lcr[LCR_BC];
  end
endmodule
